// File: rtl/ttl_gate_pkg.sv
// Function-select codes and counter sizing shared by the filtered TTL gate array.
package ttl_gate_pkg;

    localparam logic [2:0] FUNC_AND  = 3'b000;
    localparam logic [2:0] FUNC_NAND = 3'b001;
    localparam logic [2:0] FUNC_OR   = 3'b010;
    localparam logic [2:0] FUNC_NOR  = 3'b011;
    localparam logic [2:0] FUNC_XOR  = 3'b100;
    localparam logic [2:0] FUNC_XNOR = 3'b101;
    localparam logic [2:0] FUNC_HOLD = 3'b110;

    // Counter needs to reach FILTER_CYCLES-1, never less than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ttl_gate_array_filtered_if.sv
// Bundle of control, packed gate inputs and filtered outputs for the gate array.
interface ttl_gate_array_filtered_if #(
    parameter int BLOCKS   = 3,
    parameter int WIDTH_IN = 3
) ();

    logic                         Enable;
    logic [2:0]                   Func;
    logic [BLOCKS*WIDTH_IN-1:0]   A_2D;
    logic [BLOCKS-1:0]            Y;
    logic [BLOCKS-1:0]            Changed;

    modport master (
        output Enable,
        output Func,
        output A_2D,
        input  Y,
        input  Changed
    );

    modport slave (
        input  Enable,
        input  Func,
        input  A_2D,
        output Y,
        output Changed
    );

endinterface

// File: rtl/ttl_stability_filter.sv
// One-bit stability filter: output follows the sample only after it persists.
// With TTL_GATE_FILTER_EN undefined the counter is removed and y follows sample directly.
module ttl_stability_filter
    import ttl_gate_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    input  logic sample,
    output logic y,
    output logic changed
);

`ifdef TTL_GATE_FILTER_EN
    localparam int CW = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any agreement between sample and y restarts the count from zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt     <= '0;
            y       <= 1'b0;
            changed <= 1'b0;
        end else if (!Enable) begin
            changed <= 1'b0;
        end else if (sample == y) begin
            cnt     <= '0;
            changed <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            y       <= sample;
            changed <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            changed <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^FILTER_CYCLES;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            y       <= 1'b0;
            changed <= 1'b0;
        end else if (!Enable) begin
            changed <= 1'b0;
        end else begin
            y       <= sample;
            changed <= (sample != y);
        end
    end
`endif

endmodule

// File: rtl/ttl_gate_array_filtered.sv
// Array of BLOCKS run-time selectable gates with registered sampling and
// per-block stability filtering (filter present only with TTL_GATE_FILTER_EN).
module ttl_gate_array_filtered
    import ttl_gate_pkg::*;
#(
    parameter int BLOCKS        = 3,
    parameter int WIDTH_IN      = 3,
    parameter int FILTER_CYCLES = 4,
    parameter int DELAY_RISE    = 0,
    parameter int DELAY_FALL    = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    ttl_gate_array_filtered_if.slave  gate
);

    logic [BLOCKS-1:0] c_val;
    logic [BLOCKS-1:0] r_q;
    logic [BLOCKS-1:0] y_val;
    logic [BLOCKS-1:0] chg_val;

    // Output delays are a simulation-only notion and have no hardware meaning.
    logic unused_delays;
    assign unused_delays = ^{DELAY_RISE, DELAY_FALL};

    for (genvar b = 0; b < BLOCKS; b++) begin : g_block
        logic [WIDTH_IN-1:0] ins;
        logic                c_bit;

        // Input i of block b lives at bit b of the i-th BLOCKS-wide slice.
        for (genvar i = 0; i < WIDTH_IN; i++) begin : g_in
            assign ins[i] = gate.A_2D[i*BLOCKS + b];
        end

        always_comb begin
            c_bit = y_val[b];
            case (gate.Func)
                FUNC_AND:  c_bit = &ins;
                FUNC_NAND: c_bit = ~&ins;
                FUNC_OR:   c_bit = |ins;
                FUNC_NOR:  c_bit = ~|ins;
                FUNC_XOR:  c_bit = ^ins;
                FUNC_XNOR: c_bit = ~^ins;
                default:   c_bit = y_val[b];
            endcase
        end

        assign c_val[b] = c_bit;

        ttl_stability_filter #(
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_filter (
            .Clk     (Clk),
            .Reset   (Reset),
            .Enable  (gate.Enable),
            .sample  (r_q[b]),
            .y       (y_val[b]),
            .changed (chg_val[b])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= '0;
        end else if (gate.Enable) begin
            r_q <= c_val;
        end
    end

    assign gate.Y       = y_val;
    assign gate.Changed = chg_val;

endmodule

// File: tb/tb_ttl_gate_array_filtered.sv
// Directed self-checking bench for ttl_gate_array_filtered (3 blocks x 3 inputs).
// Expected latencies follow TTL_GATE_FILTER_EN so the same bench covers both builds.
module tb_ttl_gate_array_filtered;
    import ttl_gate_pkg::*;

`ifdef TTL_GATE_FILTER_EN
    localparam int LAT     = 4;
    localparam int PRE_RST = 3;
`else
    localparam int LAT     = 1;
    localparam int PRE_RST = 1;
`endif
    localparam int N = LAT + 1;

    logic Clk;
    logic Reset;
    int   compared;
    int   mismatched;

    ttl_gate_array_filtered_if #(.BLOCKS(3), .WIDTH_IN(3)) bus ();

    ttl_gate_array_filtered #(
        .BLOCKS        (3),
        .WIDTH_IN      (3),
        .FILTER_CYCLES (4),
        .DELAY_RISE    (0),
        .DELAY_FALL    (0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .gate  (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic en, input logic [2:0] func, input logic [8:0] a);
        bus.Enable = en;
        bus.Func   = func;
        bus.A_2D   = a;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [2:0] exp_y, input logic [2:0] exp_chg);
        compared++;
        assert (bus.Y === exp_y) else begin
            mismatched++;
            $error("[TB] FAIL %s Y observed=%b expected=%b", tag, bus.Y, exp_y);
        end
        compared++;
        assert (bus.Changed === exp_chg) else begin
            mismatched++;
            $error("[TB] FAIL %s Changed observed=%b expected=%b", tag, bus.Changed, exp_chg);
        end
    endtask

    // Inputs already applied; Y must hold for N-1 edges, update at edge N, then Changed drops.
    task automatic wait_latency(input string tag, input logic [2:0] old_y, input logic [2:0] new_y);
        for (int k = 1; k < N; k++) begin
            tick();
            check_output(tag, old_y, 3'b000);
        end
        tick();
        check_output(tag, new_y, old_y ^ new_y);
        tick();
        check_output(tag, new_y, 3'b000);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        Reset      = 1'b1;
        apply_stimulus(1'b1, FUNC_NOR, 9'b000_000_000);

        // Reset dominates Enable and forces zero even though NOR(0) is 1.
        tick();
        check_output("reset_0", 3'b000, 3'b000);
        tick();
        check_output("reset_1", 3'b000, 3'b000);
        Reset = 1'b0;
        wait_latency("nor_release", 3'b000, 3'b111);

        // HOLD codes freeze Y whatever the inputs do.
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, (k % 2 == 0) ? FUNC_HOLD : 3'b111, 9'($urandom));
            tick();
            check_output("hold_random", 3'b111, 3'b000);
        end

        apply_stimulus(1'b1, FUNC_AND, 9'b000_000_000);
        wait_latency("and_zero", 3'b111, 3'b000);

`ifdef TTL_GATE_FILTER_EN
        // Block 0 true for three samples then false: filter must never fire.
        apply_stimulus(1'b1, FUNC_AND, 9'b001_001_001);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("and_glitch_hi", 3'b000, 3'b000);
        end
        apply_stimulus(1'b1, FUNC_AND, 9'b001_001_001 & 9'b001_001_000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("and_glitch_lo", 3'b000, 3'b000);
        end
`endif

        apply_stimulus(1'b1, FUNC_AND, 9'b001_001_001);
        wait_latency("and_blk0_set", 3'b000, 3'b001);
        apply_stimulus(1'b1, FUNC_AND, 9'b001_001_000);
        wait_latency("and_blk0_clr", 3'b001, 3'b000);

        // One-cycle pulse on input 0 of block 2 under OR.
        apply_stimulus(1'b1, FUNC_OR, 9'b000_000_000);
        tick();
        check_output("or_idle", 3'b000, 3'b000);
        apply_stimulus(1'b1, FUNC_OR, 9'b000_000_100);
        tick();
        check_output("or_pulse_edge1", 3'b000, 3'b000);
        apply_stimulus(1'b1, FUNC_OR, 9'b000_000_000);
`ifdef TTL_GATE_FILTER_EN
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output("or_pulse_filtered", 3'b000, 3'b000);
        end
`else
        tick();
        check_output("or_pulse_rise", 3'b100, 3'b100);
        tick();
        check_output("or_pulse_fall", 3'b000, 3'b100);
        tick();
        check_output("or_pulse_quiet", 3'b000, 3'b000);
`endif

        // XOR on block 1 with Enable dropped for two edges mid-latency.
        apply_stimulus(1'b1, FUNC_XOR, 9'b000_000_000);
        tick();
        check_output("xor_idle", 3'b000, 3'b000);
        apply_stimulus(1'b1, FUNC_XOR, 9'b010_010_010);
        tick();
        check_output("xor_edge1", 3'b000, 3'b000);
        apply_stimulus(1'b0, FUNC_XOR, 9'b000_000_000);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_output("xor_disabled", 3'b000, 3'b000);
        end
        apply_stimulus(1'b1, FUNC_XOR, 9'b010_010_010);
        for (int k = 0; k < N - 2; k++) begin
            tick();
            check_output("xor_count", 3'b000, 3'b000);
        end
        tick();
        check_output("xor_update", 3'b010, 3'b010);
        tick();
        check_output("xor_settled", 3'b010, 3'b000);

        // Reset mid-filter on block 2 discards progress and restarts full latency.
        apply_stimulus(1'b1, FUNC_XOR, 9'b110_110_110);
        for (int k = 0; k < PRE_RST; k++) begin
            tick();
            check_output("pre_reset", 3'b010, 3'b000);
        end
        Reset = 1'b1;
        tick();
        check_output("mid_reset", 3'b000, 3'b000);
        Reset = 1'b0;
        wait_latency("reset_recover", 3'b000, 3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
